// File: rtl/sysbus_arbiter.sv
// rtl/sysbus_arbiter.sv - round-robin system bus arbiter with lock, turnaround and optional watchdog (ARB_TIMEOUT_EN)
module sysbus_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         rst_,
    input  logic [N_MASTERS-1:0]         req,
    input  logic [N_MASTERS-1:0]         lock,
    input  logic                         done,
    output logic [N_MASTERS-1:0]         grant,
    output logic [$clog2(N_MASTERS)-1:0] gnt_idx,
    output logic                         gnt_valid,
    output logic                         timeout
);
    localparam int IDX_W = $clog2(N_MASTERS);
    localparam logic [N_MASTERS-1:0] ONE_HOT0 = {{(N_MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

    state_t               state_q;
    logic [N_MASTERS-1:0] grant_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     ptr_d;
    logic                 valid_q;
    logic                 tmo_q;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;
    int                   cand_i;
    logic                 win_found;
    logic                 expire;
    logic                 release_own;

    // First requester at or after ptr, wrapping past the top master.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        cand_i    = 0;
        for (int k = 0; k < N_MASTERS; k++) begin
            cand_i = (int'(ptr_q) + k) % N_MASTERS;
            cand   = cand_i[IDX_W-1:0];
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign ptr_d = (int'(win_idx) == N_MASTERS - 1) ? '0 : win_idx + 1'b1;

    assign release_own = expire || (done && !lock[idx_q]) || !req[idx_q];

`ifdef ARB_TIMEOUT_EN
    logic [15:0] wdog_q;
    logic [15:0] wdog_d;

    assign wdog_d = wdog_q + 16'd1;
    // A done in the expiry cycle wins: it clears the count and releases normally.
    assign expire = !done && (wdog_q == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wdog_q <= '0;
        end else if (state_q != S_OWN || done) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            tmo_q <= 1'b0;
            case (state_q)
                S_IDLE, S_TURN: begin
                    if (win_found) begin
                        state_q <= S_OWN;
                        grant_q <= ONE_HOT0 << win_idx;
                        idx_q   <= win_idx;
                        valid_q <= 1'b1;
                        ptr_q   <= ptr_d;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_OWN: begin
                    if (release_own) begin
                        state_q <= S_TURN;
                        grant_q <= '0;
                        idx_q   <= '0;
                        valid_q <= 1'b0;
                        tmo_q   <= expire;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    idx_q   <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = tmo_q;

endmodule

// File: doc/sysbus_arbiter.md
SYSBUS_ARBITER -- requirements
Module: sysbus_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 4, number of requesters sharing the system bus (range 2..8).
REQ-002 Parameter TIMEOUT, default 255, maximum OWN cycles without done before forced release (range 1..65535).
REQ-003 Port clk  input  1  system clock; the only clock; all logic rising-edge.
REQ-004 Port rst_  input  1  asynchronous active-low reset.
REQ-005 Port req  input  N_MASTERS  per-master bus request, level, held until served.
REQ-006 Port lock  input  N_MASTERS  per-master lock; owner keeps the bus across done while its bit is high.
REQ-007 Port done  input  1  one-cycle pulse from the bus: current transfer complete.
REQ-008 Port grant  output  N_MASTERS  one-hot grant, all-zero when no owner.
REQ-009 Port gnt_idx  output  clog2(N_MASTERS)  index of current owner; 0 when no owner.
REQ-010 Port gnt_valid  output  1  high when grant is non-zero.
REQ-011 Port timeout  output  1  one-cycle pulse on forced release.

Function
REQ-012 FSM states: IDLE (no owner), OWN (grant held), TURN (one-cycle bus turnaround, grant all-zero).
REQ-013 IDLE: any req bit high -> OWN next cycle with winner granted (req-to-grant latency 1 cycle); none -> stay IDLE.
REQ-014 Winner: round-robin; search starts at pointer ptr, wraps N_MASTERS-1 -> 0; first set req bit wins.
REQ-015 On entry to OWN, ptr updates to (winner+1) mod N_MASTERS.
REQ-016 OWN release conditions: done high with lock[owner] low; req[owner] low; or watchdog expiry (REQ-020) -> TURN next cycle.
REQ-017 OWN with done high and lock[owner] high: stay OWN, grant unchanged.
REQ-018 TURN: lasts exactly one cycle; any req high -> OWN with new round-robin winner; else IDLE.
REQ-019 grant, gnt_idx, gnt_valid are registered outputs, stable for the whole OWN interval, never glitch, never two bits high.
REQ-020 Watchdog counter (16 bit) clears on OWN entry and on every done; increments each OWN cycle; reaching TIMEOUT forces release regardless of lock and pulses timeout in the TURN cycle.
REQ-021 Simultaneous done and watchdog expiry in the same cycle: treated as normal release, no timeout pulse.
REQ-022 Req bits of non-owners changing during OWN/TURN have no effect until the next arbitration point.
REQ-023 lock bits of non-owners are ignored.

Reset
REQ-024 rst_ low asynchronously forces IDLE, grant=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, watchdog=0.
REQ-025 Reset mid-OWN drops grant immediately (asynchronously); first arbitration after rst_ release occurs on the first clk edge with rst_ high.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN defined: watchdog per REQ-020/021 compiled in.
REQ-027 Macro ARB_TIMEOUT_EN undefined: no watchdog counter, timeout tied 0, OWN released only by done/lock or req drop; TIMEOUT parameter ignored.

Verification
REQ-028 After reset, req=4'b1010 -> cycle 1 grant=4'b0010, gnt_idx=1, gnt_valid=1; done pulse -> TURN (grant=0) then grant=4'b1000, gnt_idx=3.
REQ-029 req=4'b1111 held, done each OWN cycle -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001 (fairness and wrap).
REQ-030 Master 2 owns with lock[2]=1, three done pulses -> grant stays 4'b0100; lock[2]=0 then done -> TURN, next requester granted.
REQ-031 ARB_TIMEOUT_EN defined, TIMEOUT=8, owner holds req with no done -> release after 8 OWN cycles, timeout=1 for exactly one cycle, grant=0 that cycle.
REQ-032 Owner 0 drops req[0] mid-OWN without done -> TURN next cycle, grant=0, then pending master 1 granted.
REQ-033 rst_ asserted while grant=4'b0100 -> grant=0 and gnt_valid=0 before next clk edge; after rst_ release with req=4'b0110, grant=4'b0010 (ptr reset to 0).
